alu_seq: RTL and testbench

- Parametrised, registered ALU with valid/ready handshakes on its input and output.
- Extends the team's 4-bit combinational ALU operation set (ADD/SUB/AND/OR/XOR) to WIDTH bits.
- Adds shifts, a multi-cycle shift-add multiply, and status flags.
- Sits between an operand-issuing controller and a result consumer that may apply back-pressure.

---
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq -- registered WIDTH-bit ALU with valid/ready handshakes on both sides.
//
// Operations (OP): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                  101 SHL, 110 SHR (logical), 111 MUL (shift-add, WIDTH steps).
// Single-cycle ops load Result/flags on the accept edge (latency 1) and can
// stream at one per cycle. MUL occupies the block for WIDTH cycles with
// in_ready low, then presents the low WIDTH product bits.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (A, B, OP sampled on accept)
//   A, B [WIDTH]          operands
//   OP [3]                operation code
//   out_valid / out_ready result handshake; Result and flags hold while stalled
//   Result [WIDTH]        registered result
//   carry                 carry / borrow / last shifted-out bit / MUL high-half nonzero
//   zero, negative        Result == 0, Result[WIDTH-1]
//   overflow              signed overflow, ADD/SUB only
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  // Result plus the flags that travel with it.
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
  } rsp_t;

  state_t state_q, state_d;
  rsp_t   rsp_q, rsp_d, alu_rsp, mul_rsp;
  logic   out_valid_q, out_valid_d;

  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;

  logic accept, xfer, mul_done, acc_mul;

  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign acc_mul  = accept && (OP == OP_MUL);
  assign mul_done = (state_q == S_MUL) && (cnt_q == LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (acc_mul)  state_d = S_MUL;
      S_MUL:  if (mul_done) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A stalled result blocks new work; a result leaving this edge frees the slot.
  always_comb begin
    in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  end

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   ext_add, ext_sub, ext_shl, ext_shr;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] r;
  logic             c, v;

  assign shamt = B[SHW-1:0];

  always_comb begin
    ext_add = {1'b0, A} + {1'b0, B};
    ext_sub = {1'b0, A} - {1'b0, B};
    // One guard bit beyond the operand catches the last bit shifted out;
    // it stays 0 for a zero shift amount.
    ext_shl = {1'b0, A} << shamt;
    ext_shr = {A, 1'b0} >> shamt;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (OP)
      OP_ADD: begin
        r = ext_add[WIDTH-1:0];
        c = ext_add[WIDTH];
        v = (A[WIDTH-1] == B[WIDTH-1]) && (r[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        r = ext_sub[WIDTH-1:0];
        c = ext_sub[WIDTH];  // borrow, i.e. A < B unsigned
        v = (A[WIDTH-1] != B[WIDTH-1]) && (r[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: r = A & B;
      OP_OR:  r = A | B;
      OP_XOR: r = A ^ B;
      OP_SHL: begin
        r = ext_shl[WIDTH-1:0];
        c = ext_shl[WIDTH];
      end
      OP_SHR: begin
        r = ext_shr[WIDTH:1];
        c = ext_shr[0];
      end
      default: ;
    endcase
    alu_rsp = '{res: r, c: c, z: (r == '0), n: r[WIDTH-1], v: v};
  end

  // ---------------- shift-add multiplier ----------------
  // Full 2*WIDTH accumulator so the high half can report overflow via carry.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    mul_rsp = '{res: acc_step[WIDTH-1:0],
                c:   |acc_step[2*WIDTH-1:WIDTH],
                z:   (acc_step[WIDTH-1:0] == '0),
                n:   acc_step[WIDTH-1],
                v:   1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (acc_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, A};
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= mul_done ? '0 : cnt_q + SHW'(1);
    end
  end

  // ---------------- output register ----------------
  // mul_done and accept never coincide: in_ready is low in S_MUL.
  // Accepting a MUL while a result is valid implies that result leaves on
  // the same edge, so out_valid drops until the product is ready.
  always_comb begin
    rsp_d       = rsp_q;
    out_valid_d = out_valid_q;
    if (mul_done) begin
      rsp_d       = mul_rsp;
      out_valid_d = 1'b1;
    end else if (accept && !acc_mul) begin
      rsp_d       = alu_rsp;
      out_valid_d = 1'b1;
    end else if (acc_mul || xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rsp_q       <= rsp_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Result    = rsp_q.res;
  assign carry     = rsp_q.c;
  assign zero      = rsp_q.z;
  assign negative  = rsp_q.n;
  assign overflow  = rsp_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=4 instance for the base op set and a
// WIDTH=8 instance for flags, multiply, reset and back-pressure.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // WIDTH=4 instance
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, c4, z4, n4, v4;
  logic [3:0] a4 = '0, b4 = '0, r4;
  logic [2:0] op4 = '0;

  // WIDTH=8 instance
  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b1, c8, z8, n8, v8;
  logic [7:0] a8 = '0, b8 = '0, r8;
  logic [2:0] op8 = '0;

  alu_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .OP(op4), .out_valid(ov4), .out_ready(or4), .Result(r4), .carry(c4),
    .zero(z4), .negative(n4), .overflow(v4));

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .OP(op8), .out_valid(ov8), .out_ready(or8), .Result(r8), .carry(c8),
    .zero(z8), .negative(n8), .overflow(v8));

  task automatic drive8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b;
  endtask

  task automatic test_reset;
    int stale;
    @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov8: got %0b want 0", ov8); end
    checks++; if (r8 !== 8'h00) begin errors++; $display("FAIL reset_res8: got %0h want 0", r8); end
    checks++; if ({c8, z8, n8, v8} !== 4'b0000) begin errors++; $display("FAIL reset_flags8: got %b want 0000", {c8, z8, n8, v8}); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_ov4: got %0b want 0", ov4); end
    rst_n = 1'b1;
    // Start 15*15, then pull reset three cycles into the multiply.
    @(negedge clk); drive8(3'b111, 8'd15, 8'd15);
    @(posedge clk);
    @(negedge clk); iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL midmul_ov: got %0b want 0", ov8); end
    checks++; if (r8 !== 8'h00) begin errors++; $display("FAIL midmul_res: got %0h want 0", r8); end
    checks++; if ({c8, z8, n8, v8} !== 4'b0000) begin errors++; $display("FAIL midmul_flags: got %b want 0000", {c8, z8, n8, v8}); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL midmul_ready: got %0b want 1", ir8); end
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov8 !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL midmul_stale: got %0d valid cycles want 0", stale); end
  endtask

  task automatic test_legacy;
    logic [2:0] opv [5];
    logic [3:0] av [5], bv [5], ev [5];
    opv = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    av  = '{4'd4, 4'd7, 4'd5, 4'd5, 4'd8};
    bv  = '{4'd2, 4'd3, 4'd6, 4'd6, 4'd9};
    ev  = '{4'd6, 4'd4, 4'd4, 4'd7, 4'd1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL legacy_idle[%0d]: got %0b want 0", i, ov4); end
      iv4 = 1'b1; op4 = opv[i]; a4 = av[i]; b4 = bv[i];
      @(negedge clk);
      checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL legacy_valid[%0d]: got %0b want 1", i, ov4); end
      checks++; if (r4 !== ev[i]) begin errors++; $display("FAIL legacy_res[%0d]: got %0h want %0h", i, r4, ev[i]); end
      iv4 = 1'b0;
    end
  endtask

  task automatic test_flags;
    // flags packed as {carry, zero, negative, overflow}
    logic [2:0] opv [8];
    logic [7:0] av [8], bv [8], ev [8];
    logic [3:0] fv [8];
    opv = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b101, 3'b110, 3'b101, 3'b001};
    av  = '{8'd200, 8'd127, 8'd3,   8'd5,  8'h81, 8'h81, 8'h81, 8'h80};
    bv  = '{8'd100, 8'd1,   8'd5,   8'd5,  8'd1,  8'd1,  8'd8,  8'h01};
    ev  = '{8'd44,  8'd128, 8'd254, 8'd0,  8'h02, 8'h40, 8'h81, 8'h7F};
    fv  = '{4'b1000, 4'b0011, 4'b1010, 4'b0100, 4'b1000, 4'b1000, 4'b0010, 4'b0001};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive8(opv[i], av[i], bv[i]);
      @(negedge clk);
      iv8 = 1'b0;
      checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL flags_valid[%0d]: got %0b want 1", i, ov8); end
      checks++; if (r8 !== ev[i]) begin errors++; $display("FAIL flags_res[%0d]: got %0h want %0h", i, r8, ev[i]); end
      checks++; if ({c8, z8, n8, v8} !== fv[i]) begin errors++; $display("FAIL flags_czn_v[%0d]: got %b want %b", i, {c8, z8, n8, v8}, fv[i]); end
    end
  endtask

  task automatic test_mul;
    int cyc;
    @(negedge clk);
    drive8(3'b111, 8'd12, 8'd11);
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL mul_ready0: got %0b want 1", ir8); end
    @(posedge clk);  // cycle 0 accept
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) iv8 = 1'b0;
      if (k <= 8) begin
        checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL mul_busy_ready[%0d]: got %0b want 0", k, ir8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL mul_busy_valid[%0d]: got %0b want 0", k, ov8); end
      end
    end
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL mul_valid9: got %0b want 1", ov8); end
    checks++; if (r8 !== 8'd132) begin errors++; $display("FAIL mul_res132: got %0d want 132", r8); end
    checks++; if (c8 !== 1'b0) begin errors++; $display("FAIL mul_carry132: got %0b want 0", c8); end
    // Transfer of 132 and accept of 20*20 on the same edge: out_valid must drop.
    drive8(3'b111, 8'd20, 8'd20);
    @(negedge clk);
    iv8 = 1'b0;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL mul_xfer_drop: got %0b want 0", ov8); end
    cyc = 1;
    while (ov8 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL mul_latency: got cycle %0d want 9", cyc); end
    checks++; if (r8 !== 8'd144) begin errors++; $display("FAIL mul_res144: got %0d want 144", r8); end
    checks++; if ({c8, z8, n8, v8} !== 4'b1010) begin errors++; $display("FAIL mul_flags144: got %b want 1010", {c8, z8, n8, v8}); end
    @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL mul_fall: got %0b want 0", ov8); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    or8 = 1'b0;
    drive8(3'b000, 8'd1, 8'd1);
    @(negedge clk);
    // Keep a different op pending; it must not be taken while stalled.
    drive8(3'b100, 8'h0F, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, ov8); end
      checks++; if (r8 !== 8'd2) begin errors++; $display("FAIL bp_hold[%0d]: got %0h want 2", i, r8); end
      checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, ir8); end
    end
    or8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", ir8); end
    @(negedge clk);
    checks++; if (ov8 !== 1'b1 || r8 !== 8'hFF) begin errors++; $display("FAIL b2b_x1: got v=%0b r=%0h want v=1 r=ff", ov8, r8); end
    drive8(3'b100, 8'h3C, 8'h0F);
    @(negedge clk);
    checks++; if (ov8 !== 1'b1 || r8 !== 8'h33) begin errors++; $display("FAIL b2b_x2: got v=%0b r=%0h want v=1 r=33", ov8, r8); end
    drive8(3'b100, 8'hFF, 8'h01);
    @(negedge clk);
    iv8 = 1'b0;
    checks++; if (ov8 !== 1'b1 || r8 !== 8'hFE) begin errors++; $display("FAIL b2b_x3: got v=%0b r=%0h want v=1 r=fe", ov8, r8); end
    @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0b want 0", ov8); end
  endtask

  initial begin
    test_reset;
    test_legacy;
    test_flags;
    test_mul;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
